// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing constants and the line/frame total helper
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 56;
  localparam int SVGA_H_SYNC   = 120;
  localparam int SVGA_H_BP     = 64;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 37;
  localparam int SVGA_V_SYNC   = 6;
  localparam int SVGA_V_BP     = 23;
  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run enable in, raster timing outputs back to the pixel pipeline
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          en;
  logic          pix_en;
  logic          hs;
  logic          vs;
  logic          blank;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          vblank_start;
  modport master (
    input  en,
    output pix_en, hs, vs, blank, x, y, line_start, frame_start, vblank_start
  );
  modport slave (
    output en,
    input  pix_en, hs, vs, blank, x, y, line_start, frame_start, vblank_start
  );
endinterface

// File: rtl/pix_tick_gen.sv
// pix_tick_gen: divides clk by DIV into a combinational tick and a registered one-clk pix_en
module pix_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic pix_en
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pix_en_q, pix_en_d;
  // count enabled clocks; the wrap is the tick and pix_en follows it by one register
  always_comb begin
    tick     = en && cnt_q == CW'(DIV - 1);
    cnt_d    = !en ? cnt_q : tick ? '0 : cnt_q + CW'(1);
    pix_en_d = tick;
  end
  // prescaler state and pix_en register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pix_en_q <= pix_en_d;
    end
  end
  assign pix_en = pix_en_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with aligned sync, blank, coordinates and strobes
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  if (H_TOTAL > (1 << XW)) begin : g_bad_xw
    $error("vga_timing_gen: H_total does not fit in XW bits");
  end
  if (V_TOTAL > (1 << YW)) begin : g_bad_yw
    $error("vga_timing_gen: V_total does not fit in YW bits");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  logic          tick;
  logic [XW-1:0] hc_q, hc_d, x_q, x_d;
  logic [YW-1:0] vc_q, vc_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic          ls_q, ls_d, fs_q, fs_d, vbs_q, vbs_d;
  logic [31:0]   hi, vi;
  logic          h_last, new_px;
  pix_tick_gen #(.DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (vif.en),
    .tick   (tick),
    .pix_en (vif.pix_en)
  );
  // advance counters on each tick; decode the output set from the counters one clk later, strobing only on a new position
  always_comb begin
    hi      = 32'(hc_q);
    vi      = 32'(vc_q);
    h_last  = hi == H_TOTAL - 1;
    hc_d    = !tick ? hc_q : h_last ? '0 : hc_q + XW'(1);
    vc_d    = !(tick && h_last) ? vc_q : vi == V_TOTAL - 1 ? '0 : vc_q + YW'(1);
    new_px  = vif.en && (hc_q != x_q || vc_q != y_q);
    x_d     = vif.en ? hc_q : x_q;
    y_d     = vif.en ? vc_q : y_q;
    blank_d = vif.en ? (hi >= H_ACTIVE || vi >= V_ACTIVE) : blank_q;
    hs_d    = vif.en ? ((hi >= HS_BEG && hi < HS_END) ? HS_POL : !HS_POL) : hs_q;
    vs_d    = vif.en ? ((vi >= VS_BEG && vi < VS_END) ? VS_POL : !VS_POL) : vs_q;
    ls_d    = new_px && hc_q == '0;
    fs_d    = ls_d && vc_q == '0;
    vbs_d   = ls_d && vi == V_ACTIVE;
  end
  // counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= 1'b1;
      hs_q    <= !HS_POL;
      vs_q    <= !VS_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      vbs_q   <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      vbs_q   <= vbs_d;
    end
  end
  assign vif.x            = x_q;
  assign vif.y            = y_q;
  assign vif.blank        = blank_q;
  assign vif.hs           = hs_q;
  assign vif.vs           = vs_q;
  assign vif.line_start   = ls_q;
  assign vif.frame_start  = fs_q;
  assign vif.vblank_start = vbs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations against an arithmetic raster model under shared random en
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int k = 0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(10), .YW(10)) ia ();
  vga_timing_gen_if #(.XW(5), .YW(4)) ib ();
  vga_timing_gen_if #(.XW(3), .YW(3)) ic ();
  assign ia.en = en;
  assign ib.en = en;
  assign ic.en = en;

  vga_timing_gen u_a (.clk(clk), .rst_n(rst_n), .vif(ia));
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(0), .V_BP(2), .HS_POL(1'b0), .VS_POL(1'b1),
    .XW(5), .YW(4)) u_b (.clk(clk), .rst_n(rst_n), .vif(ib));
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0),
    .XW(3), .YW(3)) u_c (.clk(clk), .rst_n(rst_n), .vif(ic));

  typedef struct {
    bit pe, hs, vs, bl, ls, fs, vbs;
    int x, y;
  } exp_t;

  // k = enabled clocks since reset; pixel shown after clock k is (k-1)/div, raster-ordered
  function automatic exp_t model(int kk, bit e, int div, int ha, int hf, int hsy, int hb,
                                 int va, int vf, int vsy, int vb, bit hp, bit vp);
    exp_t r;
    int ht, vt, m;
    bit nw;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    if (kk == 0) begin
      r.pe = 0; r.hs = !hp; r.vs = !vp; r.bl = 1; r.ls = 0; r.fs = 0; r.vbs = 0; r.x = 0; r.y = 0;
      return r;
    end
    m = (kk - 1) / div;
    r.x = m % ht;
    r.y = (m / ht) % vt;
    r.bl = r.x >= ha || r.y >= va;
    r.hs = (r.x >= ha + hf && r.x < ha + hf + hsy) ? hp : !hp;
    r.vs = (r.y >= va + vf && r.y < va + vf + vsy) ? vp : !vp;
    nw = e && kk >= 2 && (kk - 1) % div == 0;
    r.pe = e && kk % div == 0;
    r.ls = nw && r.x == 0;
    r.fs = r.ls && r.y == 0;
    r.vbs = r.ls && r.y == va;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act === ex) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, ex);
  endtask

  task automatic chk_inst(input string t, input exp_t e, input logic pe, input logic hs,
                          input logic vs, input logic bl, input logic ls, input logic fs,
                          input logic vbs, input logic [31:0] x, input logic [31:0] y);
    cmp({t, ".pix_en"}, 32'(pe), 32'(e.pe));
    cmp({t, ".hs"}, 32'(hs), 32'(e.hs));
    cmp({t, ".vs"}, 32'(vs), 32'(e.vs));
    cmp({t, ".blank"}, 32'(bl), 32'(e.bl));
    cmp({t, ".line_start"}, 32'(ls), 32'(e.ls));
    cmp({t, ".frame_start"}, 32'(fs), 32'(e.fs));
    cmp({t, ".vblank_start"}, 32'(vbs), 32'(e.vbs));
    cmp({t, ".x"}, x, 32'(e.x));
    cmp({t, ".y"}, y, 32'(e.y));
  endtask

  // inputs change only just after a negedge, so values seen here are those the last posedge sampled
  always @(negedge clk) begin
    k = !rst_n ? 0 : en ? k + 1 : k;
    chk_inst("a", model(k, en && rst_n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0),
             ia.pix_en, ia.hs, ia.vs, ia.blank, ia.line_start, ia.frame_start, ia.vblank_start,
             32'(ia.x), 32'(ia.y));
    chk_inst("b", model(k, en && rst_n, 2, 10, 2, 3, 5, 6, 2, 0, 2, 1'b0, 1'b1),
             ib.pix_en, ib.hs, ib.vs, ib.blank, ib.line_start, ib.frame_start, ib.vblank_start,
             32'(ib.x), 32'(ib.y));
    chk_inst("c", model(k, en && rst_n, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0),
             ic.pix_en, ic.hs, ic.vs, ic.blank, ic.line_start, ic.frame_start, ic.vblank_start,
             32'(ic.x), 32'(ic.y));
  end

  function automatic bit cond(int w, int v);
    case (w)
      0: return 32'(ia.x) == v;
      1: return 32'(ia.x) != v;
      2: return ic.x == 3'd7 && ic.y == 3'd5;
      3: return ic.frame_start;
      4: return ic.line_start;
      5: return ib.frame_start;
      6: return ia.line_start;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int w, input int v, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(w, v) && n < lim);
    cmp($sformatf("reached_%0d_%0d", w, v), 32'(cond(w, v)), 1);
  endtask

  task automatic meas(input string nm, input int w, input int lim, input int ex);
    int n;
    wait_until(w, 0, lim, n);
    wait_until(w, 0, lim, n);
    cmp(nm, n, ex);
  endtask

  initial begin
    int n, first_pe, first_fs;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    first_pe = 0;
    first_fs = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ia.pix_en && first_pe == 0) first_pe = i;
      if (ic.frame_start && first_fs == 0) first_fs = i;
    end
    cmp("first_pix_en_clk", first_pe, 4);
    cmp("first_frame_start_clk", first_fs, 49);
    wait_until(0, 123, 5000, n);
    #1 en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      cmp("hold_x", 32'(ia.x), 123);
      cmp("hold_pix_en", 32'(ia.pix_en), 0);
      cmp("hold_line_start", 32'(ic.line_start), 0);
    end
    #1 en = 1'b1;
    wait_until(1, 123, 10, n);
    cmp("resume_x", 32'(ia.x), 124);
    wait_until(0, 655, 5000, n);
    cmp("hs_655", 32'(ia.hs), 1);
    wait_until(0, 656, 10, n);
    cmp("hs_656", 32'(ia.hs), 0);
    wait_until(0, 700, 1000, n);
    #1 rst_n = 1'b0;
    #1;
    cmp("rst_x", 32'(ia.x), 0);
    cmp("rst_y", 32'(ia.y), 0);
    cmp("rst_blank", 32'(ia.blank), 1);
    cmp("rst_hs", 32'(ia.hs), 1);
    cmp("rst_vs", 32'(ia.vs), 1);
    cmp("rst_pix_en", 32'(ia.pix_en), 0);
    cmp("rst_c_hs", 32'(ic.hs), 0);
    cmp("rst_b_vs", 32'(ib.vs), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      #1 en = ($urandom_range(0, 3) != 0);
    end
    en = 1'b1;
    meas("c_frame_period", 3, 200, 48);
    meas("c_line_period", 4, 50, 8);
    meas("b_frame_period", 5, 1000, 400);
    meas("a_line_period", 6, 8000, 3200);
    wait_until(2, 0, 100, n);
    @(negedge clk);
    cmp("wrap_x", 32'(ic.x), 0);
    cmp("wrap_y", 32'(ic.y), 0);
    cmp("wrap_frame_start", 32'(ic.frame_start), 1);
    cmp("wrap_line_start", 32'(ic.line_start), 1);
    cmp("wrap_blank", 32'(ic.blank), 0);
    wait_until(0, 751, 4000, n);
    cmp("hs_751", 32'(ia.hs), 0);
    wait_until(0, 752, 10, n);
    cmp("hs_752", 32'(ia.hs), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator for VGA-class displays, the next generation of our fixed 640x480@60 timing block. It derives a pixel-rate enable from the system clock and runs horizontal and vertical counters. From these it produces registered, mutually aligned sync, blank, coordinate and event-strobe outputs. It sits between the 100 MHz system clock domain and the pixel/framebuffer logic, and drives HS/VS pins directly.

Parameters:
CLK_DIV, 4, system clocks per pixel clock (>=1; 1 means pix_en is constantly high)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of hs (0 = active-low)
VS_POL, 0, active level of vs (0 = active-low)
XW, 10, width of x counter/output; must hold H_total-1
YW, 10, width of y counter/output; must hold V_total-1

Ports:
clk  in  1  system clock (100 MHz nominal)
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes timing
pix_en  out  1  one-clk pulse per pixel period; all outputs below change only in the clk after pix_en
hs  out  1  horizontal sync, polarity per HS_POL
vs  out  1  vertical sync, polarity per VS_POL
blank  out  1  high outside the active area
x  out  XW  current pixel column (0..H_total-1)
y  out  YW  current line (0..V_total-1)
line_start  out  1  one-clk pulse when x becomes 0
frame_start  out  1  one-clk pulse when x=0 and y=0
vblank_start  out  1  one-clk pulse when x=0 and y=V_ACTIVE

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n). All state is reset asynchronously.
- H_total = H_ACTIVE+H_FP+H_SYNC+H_BP and V_total = V_ACTIVE+V_FP+V_SYNC+V_BP, computed as localparams. Elaboration fails ($error) if H_total > 2^XW, V_total > 2^YW, or CLK_DIV < 1.
- Reset values:
  - prescaler = 0, internal hc = 0, internal vc = 0.
  - Outputs: x = 0, y = 0, blank = 1, hs = !HS_POL, vs = !VS_POL.
  - pix_en, line_start, frame_start and vblank_start all 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en = 1.
  - pix_en is registered and is high for exactly one clk when the prescaler wraps.
- Counter advance, on each pix_en:
  - hc increments.
  - At hc = H_total-1, hc wraps to 0 and vc increments.
  - At vc = V_total-1 with hc = H_total-1, vc wraps to 0.
- Output register stage, one clk after the counter update:
  - x/y take hc/vc.
  - blank = (hc >= H_ACTIVE) or (vc >= V_ACTIVE).
  - hs is active when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vs is active when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
  - All of these update in the same clk. No output may lead or lag another.
- Strobes line_start, frame_start and vblank_start:
  - Each is asserted for one clk, coincident with the x/y update it describes.
  - frame_start implies line_start in the same clk.
- First pixel after reset release:
  - The first pix_en occurs CLK_DIV clks after rst_n rises (with en = 1).
  - Counters advance to hc = 1 on that pix_en.
  - The frame at (0,0) is presented only once, and is not strobed with frame_start; the first frame_start occurs at the first wrap.
- en = 0:
  - Prescaler, counters and outputs hold their values.
  - pix_en and the strobes are forced to 0.
  - On resumption, timing continues from the held point with no skipped or repeated pixel.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously), regardless of position.
- Sync width 0 (H_SYNC or V_SYNC = 0) is legal: the corresponding sync output is never active.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60 and 800x600@72;
  - a function computing total = active+fp+sync+bp.
- Sub-module pix_tick_gen (parameter DIV) is the prescaler plus registered pix_en, and is reusable by other pixel-rate blocks.
- The h/v counters and output decode stay in vga_timing_gen.

Test Plan:
- Defaults, run 2 frames:
  - pix_en period is 4 clk.
  - 800 pix_en per line and 525 lines per frame.
  - frame_start pulses are exactly 1,680,000 clk apart.
- Defaults, sync decode:
  - hs low exactly for x = 656..751.
  - vs low exactly for y = 490..491.
  - blank = 0 iff x < 640 and y < 480.
  - vblank_start coincides with y = 480, x = 0.
- Small config (CLK_DIV=1, H 4/1/2/1, V 3/1/1/1, HS_POL=1):
  - line period is 8 clk and frame period is 48 clk.
  - hs high at x = 5..6.
  - vs low at y = 4.
- en toggled low for 37 clk mid-line at x = 123:
  - x stays 123.
  - No pix_en or strobes during the hold.
  - Next x is 124, and total frame length grows by exactly 37 clk.
- rst_n pulsed low at x = 700, y = 300:
  - outputs reach reset values within the same clk.
  - After release, the first pix_en occurs 4 clk later.
  - The first frame_start occurs at the first (0,0) wrap.
- Boundary wrap at x = 799, y = 524:
  - the next output is x = 0, y = 0, with frame_start = line_start = 1 in the same clk.
  - blank falls in that same clk.
